// File: rtl/lii_rx_unpacker.sv
`timescale 1ns/1ps
// lii_rx_unpacker: routes LII flits by dst ID into a 2-entry FIFO and unpacks each flit into LANES kernel beats
//   aclk, arstn        : clock, asynchronous active-low reset
//   lii_in_p0_*        : phy flit input (tdata/tvalid/tready, src ignored, dst matched against MY_ID)
//   img_stream_*       : kernel lane stream, lane 0 (LSBs) first
//   drop_cnt           : saturating count of misrouted flits
//   ce                 : kernel clock enable, high on each output handshake
module lii_rx_unpacker #(
    parameter int         PW    = 1024,
    parameter int         DW    = 8,
    parameter int         LANES = 4,
    parameter logic [7:0] MY_ID = 8'h01
) (
    input  logic          aclk,
    input  logic          arstn,
    input  logic [PW-1:0] lii_in_p0_tdata,
    input  logic          lii_in_p0_tvalid,
    output logic          lii_in_p0_tready,
    input  logic [7:0]    lii_in_p0_src,
    input  logic [7:0]    lii_in_p0_dst,
    output logic [DW-1:0] img_stream_tdata,
    output logic          img_stream_tvalid,
    input  logic          img_stream_tready,
    output logic [15:0]   drop_cnt,
    output logic          ce
);
    localparam int FW = LANES * DW;
    localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
    typedef enum logic {IDLE, EMIT} state_t;
    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [FW-1:0] lane_q;
    logic [FW-1:0] mem_q [2];
    logic          rd_ptr_q, wr_ptr_q, rdy_q;
    logic [1:0]    cnt_q, cnt_d;
    logic [15:0]   drop_q;
    logic          in_hs, push, drop, out_hs, last, pop;
    logic          unused_inputs;
    assign unused_inputs = ^{lii_in_p0_src, lii_in_p0_tdata};
    // rdy_q keeps tready low while in reset and rises on the first edge after release
    assign lii_in_p0_tready  = rdy_q && cnt_q != 2'd2;
    assign in_hs             = lii_in_p0_tvalid && lii_in_p0_tready;
    assign push              = in_hs && lii_in_p0_dst == MY_ID;
    assign drop              = in_hs && lii_in_p0_dst != MY_ID;
    assign img_stream_tvalid = state_q == EMIT;
    assign img_stream_tdata  = lane_q[idx_q*DW +: DW];
    assign out_hs            = img_stream_tvalid && img_stream_tready;
    assign ce                = out_hs;
    assign last              = idx_q == IW'(LANES - 1);
    // reload from the FIFO when idle, or on the last lane so flits stream without a bubble
    assign pop               = cnt_q != 2'd0 && (state_q == IDLE || (out_hs && last));
    assign cnt_d             = cnt_q + {1'b0, push} - {1'b0, pop};
    assign drop_cnt          = drop_q;
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            rdy_q    <= 1'b0;
            cnt_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            rdy_q    <= 1'b1;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_q ^ pop;
            wr_ptr_q <= wr_ptr_q ^ push;
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= lii_in_p0_tdata[FW-1:0];
    end
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lane_q  <= '0;
        end else if (pop) begin
            state_q <= EMIT;
            idx_q   <= '0;
            lane_q  <= mem_q[rd_ptr_q];
        end else if (out_hs) begin
            state_q <= last ? IDLE : EMIT;
            idx_q   <= last ? '0 : idx_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_lii_rx_unpacker.sv
`timescale 1ns/1ps
// tb_lii_rx_unpacker: scoreboard bench for lii_rx_unpacker; expected lanes queued at input handshake, compared at output handshake
module tb_lii_rx_unpacker;
    localparam int         PW    = 1024;
    localparam int         DW    = 8;
    localparam int         LANES = 4;
    localparam logic [7:0] MY_ID = 8'h01;
    logic          aclk = 1'b0;
    logic          arstn = 1'b0;
    logic [PW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic [7:0]    in_src = 8'h00;
    logic [7:0]    in_dst = 8'h00;
    logic [DW-1:0] out_tdata;
    logic          out_tvalid;
    logic          k_rdy = 1'b1;
    logic [15:0]   drop_cnt;
    logic          ce;
    int            n_checks = 0;
    int            n_fail = 0;
    int            lane_cnt = 0;
    logic [7:0]    exp_q [$];

    always #5 aclk = ~aclk;

    lii_rx_unpacker #(.PW(PW), .DW(DW), .LANES(LANES), .MY_ID(MY_ID)) dut (
        .aclk(aclk), .arstn(arstn),
        .lii_in_p0_tdata(in_tdata), .lii_in_p0_tvalid(in_tvalid), .lii_in_p0_tready(in_tready),
        .lii_in_p0_src(in_src), .lii_in_p0_dst(in_dst),
        .img_stream_tdata(out_tdata), .img_stream_tvalid(out_tvalid), .img_stream_tready(k_rdy),
        .drop_cnt(drop_cnt), .ce(ce)
    );

    task automatic send(input logic [31:0] d, input logic [7:0] dst);
        int n = 0;
        in_tdata = '0;
        in_tdata[31:0] = d;
        in_dst = dst;
        in_src = 8'($urandom);
        in_tvalid = 1'b1;
        @(negedge aclk);
        while (!in_tready && n < 100) begin
            @(negedge aclk);
            n++;
        end
        n_checks++;
        if (!in_tready) begin
            n_fail++;
            $display("FAIL send_timeout: tready=%b, required 1 within 100 cycles", in_tready);
        end else if (dst == MY_ID) begin
            for (int i = 0; i < LANES; i++) exp_q.push_back(d[i*8 +: 8]);
        end
        @(posedge aclk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge aclk);
            if (arstn && out_tvalid && k_rdy) begin
                lane_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL lane_unexpected: got %h, required no lane", out_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (out_tdata !== e) begin
                        n_fail++;
                        $display("FAIL lane_data: got %h, required %h", out_tdata, e);
                    end
                end
                n_checks++;
                if (ce !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ce_on_handshake: got %b, required 1", ce);
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_tvalid) && n < 200) begin
            @(negedge aclk);
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || out_tvalid) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d lanes pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        repeat (3) @(negedge aclk);
        n_checks++; if (in_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b, required 0", in_tready); end
        n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b, required 0", out_tvalid); end
        n_checks++; if (out_tdata !== 8'h00) begin n_fail++; $display("FAIL rst_tdata: got %h, required 00", out_tdata); end
        n_checks++; if (drop_cnt !== 16'h0000) begin n_fail++; $display("FAIL rst_drop: got %h, required 0000", drop_cnt); end
        n_checks++; if (ce !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b, required 0", ce); end
        arstn = 1'b1;
        @(posedge aclk);
        #1;
        n_checks++; if (in_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_tready: got %b, required 1", in_tready); end
    endtask

    task automatic test_single();
        int n_ce = 0;
        @(posedge aclk);
        #1;
        send(32'hDDCCBBAA, MY_ID);
        n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_early: tvalid=%b, required 0", out_tvalid); end
        @(posedge aclk);
        #1;
        n_checks++; if (out_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_latency: tvalid=%b, required 1", out_tvalid); end
        n_checks++; if (out_tdata !== 8'hAA) begin n_fail++; $display("FAIL single_first_lane: got %h, required aa", out_tdata); end
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (ce) n_ce++;
        end
        n_checks++; if (n_ce != 4) begin n_fail++; $display("FAIL single_ce_cycles: got %0d, required 4", n_ce); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        @(posedge aclk);
        #1;
        fork
            begin
                send(32'h03020100, MY_ID);
                send(32'h07060504, MY_ID);
                send(32'h0B0A0908, MY_ID);
                n_checks++; if (in_tready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_tready: got %b, required 0", in_tready); end
            end
            begin
                int n = 0;
                int run = 0;
                while (!out_tvalid && n < 50) begin
                    @(negedge aclk);
                    n++;
                end
                for (int i = 0; i < 12; i++) begin
                    if (out_tvalid) run++;
                    @(negedge aclk);
                end
                n_checks++; if (run != 12) begin n_fail++; $display("FAIL b2b_contiguous: got %0d valid cycles, required 12", run); end
            end
        join
        drain();
        n_checks++; if (in_tready !== 1'b1) begin n_fail++; $display("FAIL b2b_tready_after: got %b, required 1", in_tready); end
    endtask

    task automatic test_misroute();
        int l0 = lane_cnt;
        @(posedge aclk);
        #1;
        send(32'h13121110, MY_ID);
        send(32'hEEEEEEEE, 8'h05);
        send(32'h17161514, MY_ID);
        drain();
        n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL misroute_drop: got %0d, required 1", drop_cnt); end
        n_checks++; if (lane_cnt - l0 != 8) begin n_fail++; $display("FAIL misroute_lanes: got %0d, required 8", lane_cnt - l0); end
    endtask

    task automatic test_stall();
        int l0 = lane_cnt;
        @(posedge aclk);
        #1;
        fork
            begin
                send(32'h44332211, MY_ID);
                send(32'h88776655, MY_ID);
                send(32'hCCBBAA99, MY_ID);
            end
            begin
                int n = 0;
                @(negedge aclk);
                while (!(out_tvalid && out_tdata == 8'h22) && n < 50) begin
                    @(negedge aclk);
                    n++;
                end
                @(posedge aclk);
                #1;
                k_rdy = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge aclk);
                    n_checks++; if (out_tdata !== 8'h33) begin n_fail++; $display("FAIL stall_hold: got %h, required 33", out_tdata); end
                    n_checks++; if (ce !== 1'b0) begin n_fail++; $display("FAIL stall_ce: got %b, required 0", ce); end
                end
                n_checks++; if (in_tready !== 1'b0) begin n_fail++; $display("FAIL stall_in_tready: got %b, required 0", in_tready); end
                @(posedge aclk);
                #1;
                k_rdy = 1'b1;
            end
        join
        drain();
        n_checks++; if (lane_cnt - l0 != 12) begin n_fail++; $display("FAIL stall_lanes: got %0d, required 12", lane_cnt - l0); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int stale = 0;
        @(posedge aclk);
        #1;
        send(32'h5D5C5B5A, MY_ID);
        send(32'h6D6C6B6A, MY_ID);
        @(negedge aclk);
        while (!(out_tvalid && out_tdata == 8'h5B) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        #2;
        arstn = 1'b0;
        #1;
        n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tvalid: got %b, required 0", out_tvalid); end
        n_checks++; if (out_tdata !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tdata: got %h, required 00", out_tdata); end
        n_checks++; if (ce !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ce: got %b, required 0", ce); end
        n_checks++; if (drop_cnt !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_drop: got %h, required 0000", drop_cnt); end
        n_checks++; if (in_tready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tready: got %b, required 0", in_tready); end
        exp_q.delete();
        repeat (2) @(negedge aclk);
        arstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (out_tvalid) stale++;
        end
        n_checks++; if (stale != 0) begin n_fail++; $display("FAIL mid_rst_stale: got %0d valid cycles, required 0", stale); end
        n_checks++; if (in_tready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_release_tready: got %b, required 1", in_tready); end
        @(posedge aclk);
        #1;
        send(32'h7F7E7D7C, MY_ID);
        @(posedge aclk);
        #1;
        n_checks++; if (out_tdata !== 8'h7C || out_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_rst_new_lane0: got %h valid %b, required 7c valid 1", out_tdata, out_tvalid); end
        drain();
    endtask

    task automatic test_saturation();
        @(posedge aclk);
        #1;
        for (int i = 0; i < 65534; i++) send(32'hF0000000 | 32'(i), (i % 2) ? 8'h05 : 8'hFE);
        n_checks++; if (drop_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h, required fffe", drop_cnt); end
        send(32'hA5A5A5A5, 8'h05);
        n_checks++; if (drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h, required ffff", drop_cnt); end
        send(32'h5A5A5A5A, 8'h05);
        n_checks++; if (drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h, required ffff", drop_cnt); end
        repeat (3) @(negedge aclk);
        n_checks++; if (out_tvalid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL sat_no_lanes: tvalid %b pending %0d, required 0 and 0", out_tvalid, exp_q.size()); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_misroute();
        test_stall();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lii_rx_unpacker.md
LII_RX_UNPACKER -- requirements
Module: lii_rx_unpacker

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PW, 1024, LII phy packing width in bits.
- DW, 8, kernel stream lane width in bits.
- LANES, 4, DW lanes carried per flit; LANES*DW <= PW.
- MY_ID, 8'h01, local endpoint ID matched against dst.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- aclk, in, 1, the single clock.
- arstn, in, 1, asynchronous active-low reset.
- lii_in_p0_tdata, in, PW, phy input flit.
- lii_in_p0_tvalid, in, 1, flit valid.
- lii_in_p0_tready, out, 1, flit accept.
- lii_in_p0_src, in, 8, source ID; ignored functionally.
- lii_in_p0_dst, in, 8, destination ID.
- img_stream_tdata, out, DW, kernel input lane data.
- img_stream_tvalid, out, 1, lane valid.
- img_stream_tready, in, 1, kernel ready.
- drop_cnt, out, 16, count of misrouted flits.
- ce, out, 1, kernel clock enable.
REQ-003 There SHALL be one clock, aclk; reset SHALL be asynchronous and active-low on arstn.

Function
REQ-004 An input handshake SHALL occur on a rising edge with lii_in_p0_tvalid=1 and lii_in_p0_tready=1.
REQ-005 lii_in_p0_tready SHALL equal NOT(fifo_full) of a 2-entry flit FIFO, registered-state-derived only. It SHALL have no combinational path from img_stream_tready.
REQ-006 On a handshake with dst==MY_ID, tdata[LANES*DW-1:0] SHALL be pushed to the FIFO.
REQ-007 On a handshake with dst!=MY_ID, the flit SHALL be consumed and discarded, and drop_cnt SHALL increment, saturating at 16'hFFFF.
REQ-008 The unpacker state machine SHALL have two states, IDLE and EMIT, plus a lane index idx of width clog2(LANES).
REQ-009 IDLE -> EMIT: on the edge where the FIFO is non-empty, the head SHALL be popped into the lane register with idx=0.
REQ-010 In EMIT, img_stream_tvalid=1 and img_stream_tdata = lane register bits [idx*DW +: DW]. Lane 0 (LSBs) SHALL be emitted first.
REQ-011 In EMIT, an output handshake with idx<LANES-1 SHALL increment idx.
REQ-012 In EMIT, an output handshake with idx==LANES-1 and the FIFO non-empty SHALL pop and load the next flit with idx=0 and stay in EMIT, with no bubble cycle.
REQ-013 In EMIT, an output handshake with idx==LANES-1 and the FIFO empty SHALL go to IDLE; tvalid=0 on the next cycle.
REQ-014 While tvalid=1 and tready=0, img_stream_tdata and idx SHALL hold stable.
REQ-015 Latency: input handshake at edge k with the FIFO and unpacker empty SHALL give img_stream_tvalid=1 after edge k+1.
REQ-016 Throughput SHALL be 1 lane per cycle sustained. An input flit SHALL be accepted no more often than the FIFO drains, and no flit SHALL be lost or duplicated.
REQ-017 The FIFO SHALL support push and pop on the same edge: count unchanged, data order preserved.
REQ-018 A misrouted flit SHALL never enter the FIFO or reach img_stream.
REQ-019 ce SHALL be combinational: img_stream_tvalid AND img_stream_tready.
REQ-020 lii_in_p0_src SHALL have no effect on any output.

Reset
REQ-021 arstn=0 SHALL asynchronously force the following:
- FIFO empty; state IDLE; idx=0.
- img_stream_tvalid=0, img_stream_tdata=0.
- drop_cnt=0, ce=0.
- lii_in_p0_tready=0 while arstn=0.
REQ-022 After arstn deasserts, lii_in_p0_tready SHALL be 1 from the first edge onward.
REQ-023 Reset asserted mid-flit SHALL discard all buffered and partially emitted data. Output SHALL resume only with flits accepted after reset release.

Verification
REQ-024 Single flit, dst=8'h01, tdata low 32 bits = 32'hDDCCBBAA, tready held 1 -> lanes AA,BB,CC,DD on 4 consecutive cycles, first tvalid after edge k+1; ce=1 on those 4 cycles only.
REQ-025 Three back-to-back flits (0x03020100, 0x07060504, 0x0B0A0908) with kernel tready=1 -> 12 contiguous lanes 00..0B with no gap; input tready drops only when the FIFO is full.
REQ-026 Misrouted flit, dst=8'h05, sent between two valid flits -> drop_cnt=1, and only 8 lanes emitted, in order.
REQ-027 Kernel tready=0 for 10 cycles during lane 2 of flit 0x44332211, with 2 more flits offered -> tdata held at 0x33; input tready=0 once 2 flits are buffered; all 12 lanes later emitted in order; ce=0 while stalled.
REQ-028 arstn pulsed low during lane 1 of a flit, with one flit buffered -> outputs zero immediately; after release, no stale lanes; next new flit emitted from lane 0.
REQ-029 drop_cnt preset near saturation (65535 drops) plus one more misrouted flit -> drop_cnt stays 16'hFFFF.
